// File: rtl/aes128_iter_enc.sv
// aes128_iter_enc -- iterative AES-128 encryption, one round per clock.
//
// Purpose: accepts one plaintext/key pair, runs the initial AddRoundKey on
// acceptance, nine full rounds (SubBytes/ShiftRows/MixColumns/AddRoundKey)
// and a final round without MixColumns, then presents the ciphertext.
// The round datapath (sub_byte, shift_rows, mix_columns, key_expansion) is
// implemented locally as combinational functions.
//
// Ports:
//   clk         single clock, rising edge
//   rst         synchronous active-high reset
//   in_valid    plaintext/key offered
//   in_ready    high only in IDLE
//   plaintext   128-bit block, byte 0 = bits [127:120]
//   key         128-bit cipher key, same byte order
//   out_valid   ciphertext valid (DONE state)
//   out_ready   consumer accepts (only with AES_BACKPRESSURE_EN)
//   ciphertext  registered result, same byte order
//   busy        high in ROUND and FINAL
//
// Configuration macro: AES_BACKPRESSURE_EN
//   defined   : DONE holds until out_ready=1
//   undefined : out_valid is a one-cycle pulse, out_ready ignored
module aes128_iter_enc (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

    state_t       state_q;
    logic [127:0] st_q, rk_q, ct_q;
    logic [3:0]   rc_q;

    // ---------------- GF(2^8) / round helpers ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r, p;
        r = 8'h00;
        p = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ p;
            p = xt(p);
        end
        return r;
    endfunction

    // S-box as multiplicative inverse (x^254, which maps 0 to 0) followed by
    // the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r, p, b;
        r = 8'h01;
        p = x;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        b = r;
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    // SubBytes then ShiftRows; byte index = row + 4*col.
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return o;
    endfunction

    // Derives round key rc from round key rc-1.
    function automatic logic [127:0] key_expansion(input logic [127:0] k, input logic [3:0] rc);
        logic [7:0]  rcon;
        logic [31:0] t, w0, w1, w2, w3;
        case (rc)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])}
             ^ {rcon, 24'h0};
        w0 = k[127:96] ^ t;
        w1 = k[95:64]  ^ w0;
        w2 = k[63:32]  ^ w1;
        w3 = k[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // ---------------- shared round datapath ----------------
    logic [3:0]   rc_dp;
    logic [127:0] sr_d, key_out, rndout, final_d;

    // Only 1..10 reach the datapath; outside ROUND/FINAL a harmless 1 is fed.
    assign rc_dp   = busy ? rc_q : 4'd1;
    assign sr_d    = sub_shift(st_q);
    assign key_out = key_expansion(rk_q, rc_dp);
    assign rndout  = mix_columns(sr_d) ^ key_out;
    assign final_d = sr_d ^ key_out;

    // ---------------- control ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            st_q    <= '0;
            rk_q    <= '0;
            ct_q    <= '0;
            rc_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    st_q    <= plaintext ^ key;
                    rk_q    <= key;
                    rc_q    <= 4'd1;
                    state_q <= ROUND;
                end
                ROUND: begin
                    st_q <= rndout;
                    rk_q <= key_out;
                    rc_q <= rc_q + 4'd1;
                    if (rc_q == 4'd9) state_q <= FINAL;
                end
                FINAL: begin
                    ct_q    <= final_d;
                    state_q <= DONE;
                end
                DONE: begin
`ifdef AES_BACKPRESSURE_EN
                    if (out_ready) state_q <= IDLE;
`else
                    state_q <= IDLE;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifndef AES_BACKPRESSURE_EN
    logic unused_out_ready;
    assign unused_out_ready = out_ready;
`endif

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q == ROUND) || (state_q == FINAL);
    assign ciphertext = ct_q;

endmodule

// File: tb/tb_aes128_iter_enc.sv
module tb_aes128_iter_enc;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] plaintext = '0;
    logic [127:0] key = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] ciphertext;
    logic         busy;

    aes128_iter_enc dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .plaintext(plaintext), .key(key), .out_valid(out_valid),
        .out_ready(out_ready), .ciphertext(ciphertext), .busy(busy)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] C1_K  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_P  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_P   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_C   = 128'h3925841d02dc09fbdc118597196a0b32;

    int n_pass = 0;
    int n_tot  = 0;
    bit chk_en = 1'b0;
    bit rnd_ordy = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [7:0] sb [256];

    // S-box built from the generator-3 walk over GF(2^8).
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    function automatic logic [7:0] x2(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] model_enc(input logic [127:0] pt, input logic [127:0] k);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   n [16];
        logic [31:0]  t;
        logic [7:0]   rcon;
        logic [127:0] o;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rcon, 24'h0};
                rcon = x2(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) n[i] = sb[s[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
            if (r < 10)
                for (int c = 0; c < 4; c++) begin
                    s[4*c]   = x2(n[4*c]) ^ x2(n[4*c+1]) ^ n[4*c+1] ^ n[4*c+2] ^ n[4*c+3];
                    s[4*c+1] = n[4*c] ^ x2(n[4*c+1]) ^ x2(n[4*c+2]) ^ n[4*c+2] ^ n[4*c+3];
                    s[4*c+2] = n[4*c] ^ n[4*c+1] ^ x2(n[4*c+2]) ^ x2(n[4*c+3]) ^ n[4*c+3];
                    s[4*c+3] = x2(n[4*c]) ^ n[4*c] ^ n[4*c+1] ^ n[4*c+2] ^ x2(n[4*c+3]);
                end
            else
                for (int i = 0; i < 16; i++) s[i] = n[i];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    // Cycle-level expectation: cnt = -1 idle, 0..9 working, 10 result shown.
    int           cnt = -1;
    logic [127:0] exp_ct = '0;
    logic [127:0] pend = '0;

    always @(posedge clk) begin
        if (rst) begin
            cnt    <= -1;
            exp_ct <= '0;
        end else if (cnt == -1) begin
            if (in_valid) begin
                pend <= model_enc(plaintext, key);
                cnt  <= 0;
            end
        end else if (cnt < 10) begin
            cnt <= cnt + 1;
            if (cnt == 9) exp_ct <= pend;
        end else begin
`ifdef AES_BACKPRESSURE_EN
            if (out_ready) cnt <= -1;
`else
            cnt <= -1;
`endif
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_in_ready",   in_ready,   cnt == -1);
            chk("cyc_busy",       busy,       (cnt >= 0) && (cnt <= 9));
            chk("cyc_out_valid",  out_valid,  cnt == 10);
            chk("cyc_ciphertext", ciphertext, exp_ct);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ordy) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!in_ready && n < 60) begin tick(); n++; end
        chk("idle_timeout", in_ready, 1'b1);
    endtask

    // Called right after the acceptance edge; returns edges until out_valid.
    task automatic wait_ov(input string name, input logic [127:0] want, output int n);
        n = 0;
        while (!out_valid && n < 60) begin tick(); n++; end
        chk({name, "_ov"}, out_valid, 1'b1);
        chk(name, ciphertext, want);
    endtask

    task automatic issue(input logic [127:0] p, input logic [127:0] k);
        wait_idle();
        plaintext = p;
        key       = k;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
    endtask

    initial begin
        int n, k;
        logic [127:0] rp, rk, hold;
        build_sbox();

        chk("model_C1", model_enc(C1_P, C1_K), C1_C);
        chk("model_B",  model_enc(B_P,  B_K),  B_C);

        // reset
        tick(); tick();
        rst = 1'b0;
        chk("rst_in_ready",  in_ready,   1'b1);
        chk("rst_out_valid", out_valid,  1'b0);
        chk("rst_busy",      busy,       1'b0);
        chk("rst_ct",        ciphertext, 128'h0);
        chk_en = 1'b1;

        // C.1 with a single-cycle in_valid; latency 10
        issue(C1_P, C1_K);
        wait_ov("c1_ct", C1_C, n);
        chk("c1_latency", 128'(n), 128'd10);

        // B with in_valid held: two identical results, second accept after DONE->IDLE
        wait_idle();
        plaintext = B_P; key = B_K; in_valid = 1'b1;
        tick();
        wait_ov("b_ct_first", B_C, n);
        tick();
        chk("b_idle_again", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("b_second_accept", in_ready, 1'b0);
        wait_ov("b_ct_second", B_C, n);
        chk("b_latency2", 128'(n), 128'd10);

        // Noise on inputs while busy must be ignored
        wait_idle();
        plaintext = C1_P; key = C1_K; in_valid = 1'b1;
        tick();
        k = 0;
        while (!in_ready && k < 40) begin
            k++;
            plaintext = {$urandom, $urandom, $urandom, $urandom};
            key       = {$urandom, $urandom, $urandom, $urandom};
            in_valid  = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid = 1'b0;
        chk("noise_ready_low_cycles", 128'(k), 128'd11);
        chk("noise_ct", ciphertext, C1_C);

        // Reset mid-operation (round 5)
        rp = {$urandom, $urandom, $urandom, $urandom};
        rk = {$urandom, $urandom, $urandom, $urandom};
        issue(rp, rk);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_in_ready",  in_ready,  1'b1);
        chk("abort_busy",      busy,      1'b0);
        chk("abort_out_valid", out_valid, 1'b0);
        k = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid) k++;
            tick();
        end
        chk("abort_no_pulse", 128'(k), 128'd0);
        issue(C1_P, C1_K);
        wait_ov("after_abort_ct", C1_C, n);

        // out_valid length with out_ready low
        wait_idle();
        out_ready = 1'b0;
        rp = {$urandom, $urandom, $urandom, $urandom};
        issue(rp, B_K);
        wait_ov("ordy_ct", model_enc(rp, B_K), n);
        hold = ciphertext;
`ifdef AES_BACKPRESSURE_EN
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("bp_hold_ov", out_valid, 1'b1);
            chk("bp_hold_ct", ciphertext, hold);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_release_ov",    out_valid, 1'b0);
        chk("bp_release_ready", in_ready,  1'b1);
`else
        tick();
        chk("pulse_ov_low",   out_valid,  1'b0);
        chk("pulse_ct_hold",  ciphertext, hold);
        out_ready = 1'b1;
`endif

        // Back-to-back C.1 then B at earliest in_ready
        wait_idle();
        plaintext = C1_P; key = C1_K; in_valid = 1'b1;
        tick();
        plaintext = B_P; key = B_K;
        wait_ov("b2b_first", C1_C, n);
        tick();
        tick();
        in_valid = 1'b0;
        chk("b2b_hold_ct", ciphertext, C1_C);
        wait_ov("b2b_second", B_C, n);

        // Randomized traffic with random out_ready
        rnd_ordy = 1'b1;
        for (int t = 0; t < 25; t++) begin
            wait_idle();
            plaintext = {$urandom, $urandom, $urandom, $urandom};
            key       = {$urandom, $urandom, $urandom, $urandom};
            in_valid  = 1'b1;
            tick();
            in_valid  = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 14)) tick();
            in_valid  = 1'b0;
        end
        rnd_ordy  = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/aes128_iter_enc.md
# aes128_iter_enc

Iterative AES-128 encryption controller that sequences the existing single-round datapath (`round`, with its `key_expansion`, `sub_byte`, `shift_rows`, `mix_columns`) over ten rounds.
- Upstream side: valid/ready handshake to accept one plaintext/key pair.
- Per round: drives `rc`, `data` and `key_in`, and registers `rndout`/`key_out`.
- Last round: handled with a local final-round path that omits MixColumns.
- Downstream side: ciphertext is presented through a valid/ready (or pulse) handshake.

## Interface
Parameters: none (AES-128 only).

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  plaintext/key pair offered
- in_ready  output  1  block can accept a pair (high only in IDLE)
- plaintext  input  128  input block; byte 0 = bits [127:120]
- key  input  128  cipher key, same byte order
- out_valid  output  1  ciphertext valid
- out_ready  input  1  consumer accepts ciphertext (used only with `AES_BACKPRESSURE_EN`)
- ciphertext  output  128  registered result, same byte order
- busy  output  1  high in ROUND and FINAL

## Operation
- Internal registers:
  - `st` (128): cipher state.
  - `rk` (128): current round key.
  - `rc` (4): round number.
  - FSM: IDLE, ROUND, FINAL, DONE.
- **IDLE**: in_ready=1. On in_valid, capture `st <= plaintext ^ key` (initial AddRoundKey), `rk <= key`, `rc <= 1`, and go to ROUND.
- **ROUND**: the round instance gets `data=st`, `key_in=rk`, `rc=rc`. Each cycle update `st <= rndout`, `rk <= key_out`, `rc <= rc+1`.
  - rc==9 this cycle: go to FINAL (rc becomes 10).
- **FINAL**: `key_expansion` is driven with rc=10 and rk.
  - Update `ciphertext <= key_out ^ ShiftRows(SubBytes(st))`.
  - Go to DONE.
  - The same `key_expansion` instance is shared by muxing nothing; rc/rk already carry round 10.
- **DONE**: out_valid=1, in_ready=0. Exit condition depends on configuration (see below); the next state is IDLE.
- rc range is 1..10 only. Values 0 and 11–15 are never driven to the round datapath; in IDLE/DONE, rc holds its last value.
- ciphertext holds its value from DONE entry until the next FINAL write. It does not change on leaving DONE or on a new acceptance.
- in_valid while not IDLE: ignored; the plaintext/key inputs are not sampled.
- Reset mid-operation: the FSM goes to IDLE on the edge where rst=1. The result is discarded and out_valid is never raised for the aborted block.

## Timing
- Reset values: in_ready=1 (FSM=IDLE), out_valid=0, busy=0, ciphertext=0, st=0, rk=0, rc=0.
- rst has priority over in_valid, out_ready and FSM transitions.
- Acceptance: occurs on edge E0 when in_ready & in_valid; in_ready falls after E0.
- Rounds 1..9 complete on edges E1..E9; the final round completes on E10.
- out_valid rises after E10; latency is 10 cycles from acceptance edge to out_valid.
- in_ready rises again in the cycle after DONE is left.
- Minimum issue interval is 12 cycles (pulse mode).
- in_valid/out_ready are combinationally unused in outputs; all outputs are registered or FSM-decoded.

## Configuration
- **`AES_BACKPRESSURE_EN` defined**:
  - DONE holds out_valid=1 and ciphertext stable until a cycle with out_ready=1; the FSM leaves on that edge.
  - out_ready=1 on the DONE entry cycle gives a one-cycle out_valid.
- **Not defined**:
  - out_ready is ignored (left unconnected internally).
  - out_valid is a single-cycle pulse; DONE always lasts one cycle.

## Test plan
- FIPS-197 C.1: key=000102030405060708090a0b0c0d0e0f, plaintext=00112233445566778899aabbccddeeff, one-cycle in_valid → out_valid exactly 10 cycles after acceptance, ciphertext=69c4e0d86a7b0430d8cdb78070b4c55a.
- FIPS-197 B: key=2b7e151628aed2a6abf7158809cf4f3c, plaintext=3243f6a8885a308d313198a2e0370734 → 3925841d02dc09fbdc118597196a0b32; in_valid held high throughout → second identical result, second acceptance only after DONE→IDLE.
- Inputs changed and in_valid toggled while busy=1 → no effect; result still matches the first vector; in_ready=0 for 11 cycles.
- rst=1 for one cycle at round 5 → next cycle in_ready=1, busy=0, out_valid=0 with no later pulse; new C.1 vector then produces the correct result.
- With `AES_BACKPRESSURE_EN`: out_ready=0 for 7 cycles after out_valid → out_valid and ciphertext stable for 8 cycles, IDLE after the out_ready edge. Without the macro: out_valid high exactly 1 cycle regardless of out_ready.
- Back-to-back: C.1 then B issued at the earliest in_ready → both results correct, in order, and ciphertext unchanged between DONE exit and the next FINAL.
